// File: rtl/wr_decode32.sv
// Register-file write decoder: 2-entry request FIFO feeding a registered one-hot write strobe.
// Optional register-0 write protection via `define WR_DECODE32_ZERO_REG_EN.
module wr_decode32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_addr,
  input  logic [31:0] in_data,
  input  logic        hold,
  output logic        wr_valid,
  output logic [31:0] we_onehot,
  output logic [31:0] wr_data,
  output logic [1:0]  occupancy
);

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_occ;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [AW-1:0] w_head_addr;
  logic [DW-1:0] w_head_data;

  // Ready depends only on the entry count, never on hold or in_valid.
  always_comb begin
    in_ready    = (r_occ != 2'(DEPTH));
    w_push      = in_valid && in_ready;
    w_pop       = (r_occ != 2'd0) && !hold;
    w_head_addr = r_addr[r_rptr];
    w_head_data = r_data[r_rptr];
`ifdef WR_DECODE32_ZERO_REG_EN
    // Register 0 is read-only: the entry is still consumed, but no strobe goes out.
    w_issue     = w_pop && (w_head_addr != AW'(0));
`else
    w_issue     = w_pop;
`endif
  end

  // FIFO storage; contents are don't-care while the slot is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wptr] <= in_addr;
      r_data[r_wptr] <= in_data;
    end
  end

  // Pointers and count; simultaneous push/pop leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_occ <= r_occ + 2'd1;
      else if (!w_push && w_pop) r_occ <= r_occ - 2'd1;
    end
  end

  // Output stage: one-cycle strobe, data held between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid  <= 1'b0;
      we_onehot <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid  <= w_issue;
      we_onehot <= w_issue ? (DW'(1) << w_head_addr) : '0;
      if (w_issue) wr_data <= w_head_data;
    end
  end

  assign occupancy = r_occ;

endmodule
